// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_pkg
//  Description : Shared definitions for the memory-mapped UART transmitter:
//                register offsets (addr[3:2]), STATUS bit positions and the
//                transmit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] c_reg_data   = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_baud   = 2'd2;
    localparam logic [1:0] c_reg_ctrl   = 2'd3;

    // STATUS bit positions
    localparam int c_st_full_bit  = 0;
    localparam int c_st_empty_bit = 1;
    localparam int c_st_busy_bit  = 2;
    localparam int c_st_ovf_bit   = 3;
    localparam int c_st_cnt_lsb   = 8;

    // Transmit FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage : mmio_uart_pkg
`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO using read/write pointers that carry one
//                extra wrap bit, so full and empty are distinguished without
//                a separate occupancy register.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push_i, din_i   - write request and data (ignored when full)
//                pop_i, dout_o   - read request (ignored when empty), head data
//                full_o, empty_o - occupancy flags
//                count_o         - number of stored entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int              c_aw  = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_one = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw:0]    wr_ptr_q;
    logic [c_aw:0]    wr_ptr_d;
    logic [c_aw:0]    rd_ptr_q;
    logic [c_aw:0]    rd_ptr_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers match in address bits but differ in the wrap bit when full
    assign full_o    = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                       (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign dout_o    = mem_q[rd_ptr_q[c_aw-1:0]];

    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + c_one;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + c_one;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only visible between the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[c_aw-1:0]] <= din_i;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter. Software stores bytes
//                to DATA; they are queued in a FIFO and shifted out LSB
//                first on txd_o at BAUD_DIV clock cycles per bit.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                sel_i      - window select from the address decoder
//                we_i       - store strobe
//                addr_i     - byte address, addr_i[3:2] selects the register
//                wd_i       - store data
//                rd_o       - combinational read data (0 when not selected)
//                txd_o      - registered serial output, idle high
//                irq_o      - registered, high when FIFO empty and FSM idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o,
    output logic        txd_o,
    output logic        irq_o
);

    localparam int              c_cw       = $clog2(DEPTH) + 1;
    localparam logic [c_cw-1:0] c_cnt_one  = 1;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [15:0]  baud_div_q, baud_div_d;
    logic         enable_q,   enable_d;
    logic         overflow_q, overflow_d;

    uart_state_e  state_q,    state_d;
    logic [7:0]   shift_q,    shift_d;
    logic [2:0]   bit_cnt_q,  bit_cnt_d;
    logic [15:0]  baud_cnt_q, baud_cnt_d;
    logic         txd_q,      txd_d;
    logic         irq_q,      irq_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_wr_data;
    logic w_wr_status;
    logic w_wr_baud;
    logic w_wr_ctrl;

    assign w_wr        = sel_i & we_i;
    assign w_wr_data   = w_wr && (addr_i[3:2] == c_reg_data);
    assign w_wr_status = w_wr && (addr_i[3:2] == c_reg_status);
    assign w_wr_baud   = w_wr && (addr_i[3:2] == c_reg_baud);
    assign w_wr_ctrl   = w_wr && (addr_i[3:2] == c_reg_ctrl);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]      w_fifo_dout;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_cw-1:0] w_fifo_count;
    logic            w_pop;
    logic            w_push_acc;
    logic            w_empty_next;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_wr_data),
        .pop_i   (w_pop),
        .din_i   (wd_i[7:0]),
        .dout_o  (w_fifo_dout),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign w_push_acc   = w_wr_data & ~w_fifo_full;

    // FIFO occupancy after this edge; pops only happen when non-empty
    assign w_empty_next = (w_fifo_empty & ~w_push_acc) |
                          ((w_fifo_count == c_cnt_one) & w_pop & ~w_push_acc);

    // ------------------------------------------------------------------
    // Control / configuration registers
    // ------------------------------------------------------------------
    always_comb begin
        baud_div_d = baud_div_q;
        enable_d   = enable_q;
        overflow_d = overflow_q;

        // A zero divisor would stall the bit timer, so it is stored as 1
        if (w_wr_baud) begin
            baud_div_d = (wd_i[15:0] == 16'd0) ? 16'd1 : wd_i[15:0];
        end
        if (w_wr_ctrl) begin
            enable_d = wd_i[0];
        end
        // Rejected push and clear-on-write cannot coincide (different offsets)
        if (w_wr_data && w_fifo_full) begin
            overflow_d = 1'b1;
        end else if (w_wr_status && wd_i[c_st_ovf_bit]) begin
            overflow_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM, baud counter and shifter
    // ------------------------------------------------------------------
    logic w_bit_end;
    assign w_bit_end = (baud_cnt_q == 16'd1);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        w_pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_q && !w_fifo_empty) begin
                    w_pop      = 1'b1;
                    state_d    = S_START;
                    shift_d    = w_fifo_dout;
                    bit_cnt_d  = 3'd0;
                    baud_cnt_d = baud_div_q;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    state_d    = S_DATA;
                    baud_cnt_d = baud_div_q;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    shift_d    = {1'b0, shift_q[7:1]};
                    baud_cnt_d = baud_div_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next frame when data is waiting
                    if (enable_q && !w_fifo_empty) begin
                        w_pop      = 1'b1;
                        state_d    = S_START;
                        shift_d    = w_fifo_dout;
                        bit_cnt_d  = 3'd0;
                        baud_cnt_d = baud_div_q;
                    end else begin
                        state_d    = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level is a function of where the FSM lands, so txd_q is
        // aligned with the state register
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        irq_d = w_empty_next && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div_q <= DEFAULT_DIV;
            enable_q   <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            txd_q      <= 1'b1;
            irq_q      <= 1'b1;
        end else begin
            baud_div_q <= baud_div_d;
            enable_q   <= enable_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            txd_q      <= txd_d;
            irq_q      <= irq_d;
        end
    end

    assign txd_o = txd_q;
    assign irq_o = irq_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_count_ext;
    logic [31:0] w_status;

    assign w_count_ext = 32'(w_fifo_count);

    always_comb begin
        w_status                  = 32'd0;
        w_status[c_st_full_bit]   = w_fifo_full;
        w_status[c_st_empty_bit]  = w_fifo_empty;
        w_status[c_st_busy_bit]   = (state_q != S_IDLE);
        w_status[c_st_ovf_bit]    = overflow_q;
        w_status[c_st_cnt_lsb+:4] = w_count_ext[3:0];
    end

    always_comb begin
        rd_o = 32'd0;
        if (sel_i) begin
            case (addr_i[3:2])
                c_reg_status: rd_o = w_status;
                c_reg_baud:   rd_o = {16'd0, baud_div_q};
                c_reg_ctrl:   rd_o = {31'd0, enable_q};
                default:      rd_o = 32'd0;
            endcase
        end
    end

    // Address and data bits outside the register map are don't-care
    logic w_unused_bits;
    assign w_unused_bits = ^{addr_i[31:4], addr_i[1:0], wd_i[31:16],
                             w_count_ext[31:4]};

endmodule : mmio_uart_tx
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Directed self-checking bench for mmio_uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    logic        clk;
    logic        rst;
    logic        sel_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wd_i;
    logic [31:0] rd_o;
    logic        txd_o;
    logic        irq_o;

    int n_cmp;
    int n_err;

    mmio_uart_tx #(
        .DEPTH       (8),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sel_i  (sel_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wd_i   (wd_i),
        .rd_o   (rd_o),
        .txd_o  (txd_o),
        .irq_o  (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Store that takes effect on the next rising edge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sel_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = {28'd0, a};
        wd_i   = d;
        @(posedge clk);
        #1;
        sel_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = 32'd0;
        wd_i   = 32'd0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] expv, input string tag);
        sel_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = {28'd0, a};
        #1;
        chk(tag, rd_o, expv);
        sel_i  = 1'b0;
        addr_i = 32'd0;
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] b;
        logic       ebit;
        int         k;
        int         pos;

        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        sel_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = 32'd0;
        wd_i   = 32'd0;
        repeat (2) tick();
        rst = 1'b0;

        // ---------------- Reset state ----------------
        chk("rst_txd", {31'd0, txd_o}, 32'd1);
        chk("rst_irq", {31'd0, irq_o}, 32'd1);
        rd_chk(4'h4, 32'h002, "rst_status");
        rd_chk(4'h8, 32'd434, "rst_baud");
        rd_chk(4'hC, 32'd1,   "rst_ctrl");

        // ---------------- Single frame 0xA5 at div 4 ----------------
        wr(4'h8, 32'd4);
        wr(4'h0, 32'hA5);
        chk("a5_txd_pre", {31'd0, txd_o}, 32'd1);
        chk("a5_irq_pre", {31'd0, irq_o}, 32'd0);
        rd_chk(4'h4, 32'h100, "a5_status_queued");
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                chk("a5_txd", {31'd0, txd_o}, {31'd0, frame[i]});
                if (i == 5 && j == 0) rd_chk(4'h4, 32'h006, "a5_status_busy");
            end
        end
        chk("a5_irq_stop", {31'd0, irq_o}, 32'd0);
        tick();
        chk("a5_irq_done", {31'd0, irq_o}, 32'd1);
        chk("a5_txd_idle", {31'd0, txd_o}, 32'd1);
        rd_chk(4'h4, 32'h002, "a5_status_idle");

        // ---------------- Overflow with enable=0 ----------------
        wr(4'hC, 32'd0);
        for (int i = 0; i < 9; i++) wr(4'h0, 32'h10 + i);
        rd_chk(4'h4, 32'h809, "ovf_status");
        chk("ovf_irq", {31'd0, irq_o}, 32'd0);
        // Store without select must be ignored
        sel_i = 1'b0; we_i = 1'b1; addr_i = 32'h4; wd_i = 32'h8;
        tick();
        we_i = 1'b0; addr_i = 32'd0; wd_i = 32'd0;
        rd_chk(4'h4, 32'h809, "nosel_write");
        sel_i = 1'b0; addr_i = 32'h8;
        #1;
        chk("nosel_rd", rd_o, 32'd0);
        addr_i = 32'd0;
        wr(4'h4, 32'h8);
        rd_chk(4'h4, 32'h801, "ovf_cleared");
        rd_chk(4'h7, 32'h801, "status_lowaddr");
        rd_chk(4'h0, 32'h0,   "data_reads0");
        rd_chk(4'hC, 32'h0,   "ctrl_off");
        wr(4'h8, 32'h0001_0000);
        rd_chk(4'h8, 32'd1, "baud_zero_is1");
        wr(4'h8, 32'd2);
        rd_chk(4'hB, 32'd2, "baud_div2");

        // ---------------- Drain 8 frames back-to-back at div 2 ----------------
        wr(4'hC, 32'd1);
        chk("drain_txd_pre", {31'd0, txd_o}, 32'd1);
        for (int i = 0; i < 160; i++) begin
            tick();
            k   = i / 20;
            pos = (i % 20) / 2;
            b   = 8'h10 + 8'(k);
            if (pos == 0)      ebit = 1'b0;
            else if (pos == 9) ebit = 1'b1;
            else               ebit = b[pos-1];
            chk("drain_txd", {31'd0, txd_o}, {31'd0, ebit});
        end
        chk("drain_irq_last", {31'd0, irq_o}, 32'd0);
        tick();
        chk("drain_irq_done", {31'd0, irq_o}, 32'd1);
        rd_chk(4'h4, 32'h002, "drain_status");

        // ---------------- BAUD_DIV change mid-bit ----------------
        wr(4'h0, 32'h05);
        tick();
        chk("baud_start0", {31'd0, txd_o}, 32'd0);
        tick();
        chk("baud_start1", {31'd0, txd_o}, 32'd0);
        wr(4'h8, 32'd8);
        chk("baud_bit0a", {31'd0, txd_o}, 32'd1);
        tick();
        chk("baud_bit0b", {31'd0, txd_o}, 32'd1);
        b = 8'h05;
        for (int i = 1; i < 9; i++) begin
            ebit = (i == 8) ? 1'b1 : b[i];
            for (int j = 0; j < 8; j++) begin
                tick();
                chk("baud_slow", {31'd0, txd_o}, {31'd0, ebit});
            end
        end
        tick();
        chk("baud_irq_done", {31'd0, irq_o}, 32'd1);

        // ---------------- Reset during DATA ----------------
        wr(4'h0, 32'h3C);
        wr(4'h0, 32'h55);
        repeat (10) tick();
        rd_chk(4'h4, 32'h104, "pre_rst_status");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_txd", {31'd0, txd_o}, 32'd1);
        chk("rst_mid_irq", {31'd0, irq_o}, 32'd1);
        rd_chk(4'h4, 32'h002, "rst_mid_status");
        rd_chk(4'h8, 32'd434, "rst_mid_baud");
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("rst_quiet_txd", {31'd0, txd_o}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mmio_uart_tx
`default_nettype wire
